// File: rtl/trigger_qualifier.sv
// trigger_qualifier: debounced, edge-counting trigger with fire/holdoff handshake and sticky timeout fault
module trigger_qualifier #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EDGE_COUNT = 1,
  parameter int unsigned HOLDOFF_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd204_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig_in,
  input  logic        arm,
  input  logic        edge_sel,
  input  logic        glitch_done,
  output logic        trigger,
  output logic        armed_indicator,
  output logic        fault_indicator,
  output logic [15:0] edge_count
);
  typedef enum logic [1:0] {IDLE, ARMED, FIRE, HOLDOFF} state_t;
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] EC_T = 16'(EDGE_COUNT);
  localparam logic [32:0] HO_T = {1'b0, 32'(HOLDOFF_CYCLES)};
  state_t state;
  logic [1:0] rst_sync, sync;
  logic rst_i, filt, filt_d, pol, qual, ho_done;
  logic [15:0] db_cnt, cnt_inc;
  logic [31:0] tcnt, hcnt, tcnt_inc;
  // reset asserts immediately but releases two clk edges after rst_n rises
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_i = rst_sync[1];
  always_comb begin
    qual = pol ? filt_d & ~filt : filt & ~filt_d;
    cnt_inc = &edge_count ? edge_count : edge_count + 16'd1;
    tcnt_inc = tcnt + 32'd1;
    ho_done = {1'b0, hcnt} + 33'd1 >= HO_T;
  end
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      sync <= '0;
      filt <= 1'b0;
      filt_d <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync <= {sync[0], trig_in};
      filt_d <= filt;
      db_cnt <= (sync[1] == filt || db_cnt == DB_LAST) ? '0 : db_cnt + 16'd1;
      if (sync[1] != filt && db_cnt == DB_LAST) filt <= sync[1];
    end
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      state <= IDLE;
      trigger <= 1'b0;
      armed_indicator <= 1'b0;
      fault_indicator <= 1'b0;
      edge_count <= '0;
      pol <= 1'b0;
      tcnt <= '0;
      hcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          pol <= edge_sel;
          if (arm) begin
            state <= ARMED;
            armed_indicator <= 1'b1;
            fault_indicator <= 1'b0;
          end
        end
        ARMED:
          if (!arm) begin
            state <= IDLE;
            armed_indicator <= 1'b0;
            edge_count <= '0;
          end else if (qual) begin
            edge_count <= cnt_inc;
            if (cnt_inc == EC_T) begin
              state <= FIRE;
              trigger <= 1'b1;
              armed_indicator <= 1'b0;
              tcnt <= '0;
            end
          end
        FIRE:
          if (glitch_done || tcnt_inc == TIMEOUT_CYCLES) begin
            state <= HOLDOFF;
            trigger <= 1'b0;
            hcnt <= '0;
            fault_indicator <= fault_indicator | ~glitch_done;
          end else tcnt <= tcnt_inc;
        HOLDOFF:
          if (!glitch_done && ho_done) begin
            state <= IDLE;
            edge_count <= '0;
          end else if (!ho_done) hcnt <= hcnt + 32'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/trigger_qualifier.md
TRIGGER_QUALIFIER -- requirements
Module: trigger_qualifier

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable clk cycles before the filtered level changes (range 1..65535).
REQ-002 Parameter EDGE_COUNT, default 1, meaning qualifying edges required to fire (range 1..65535).
REQ-003 Parameter HOLDOFF_CYCLES, default 1024, meaning clk cycles in HOLDOFF before re-arming (range 0..2^32-1).
REQ-004 Parameter TIMEOUT_CYCLES, default 32'd204_000_000, meaning maximum clk cycles in FIRE waiting for done (1 s at 204 MHz).
REQ-005 clk  input  1  system clock (PLL output); the only clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 trig_in  input  1  raw external target signal, asynchronous to clk.
REQ-008 arm  input  1  level; 1 enables qualification.
REQ-009 edge_sel  input  1  0 = rising edges qualify, 1 = falling edges qualify; sampled only in IDLE.
REQ-010 glitch_done  input  1  level from the downstream glitch generator; 1 = pulse completed.
REQ-011 trigger  output  1  level to the downstream glitch generator; registered.
REQ-012 armed_indicator  output  1  1 while in ARMED.
REQ-013 fault_indicator  output  1  sticky timeout flag.
REQ-014 edge_count  output  16  qualifying edges seen in the current arming.

Function
REQ-015 trig_in shall pass through a 2-flop synchronizer; the filtered level shall change only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce shall restart the stability counter.
REQ-016 A qualifying edge shall be a filtered-level transition in the polarity latched from edge_sel; it shall be detected one cycle after the filtered level changes.
REQ-017 FSM states: IDLE, ARMED, FIRE, HOLDOFF; all transitions occur on the rising edge of clk.
REQ-018 IDLE: trigger=0, edge_count=0; edge_sel shall be latched; when arm=1, go to ARMED the next cycle.
REQ-019 ARMED: armed_indicator=1; each qualifying edge increments edge_count; on the edge that makes the count equal EDGE_COUNT, go to FIRE, with trigger=1 registered on the same edge.
REQ-020 ARMED with arm=0: return to IDLE and clear edge_count; if arm falls in the same cycle as the final qualifying edge, arm=0 wins and no fire occurs.
REQ-021 FIRE: trigger held at 1; the timeout counter increments each cycle; on glitch_done=1, go to HOLDOFF and drop trigger to 0.
REQ-022 FIRE timeout: when the timeout counter equals TIMEOUT_CYCLES without glitch_done, set fault_indicator=1, drop trigger, and go to HOLDOFF; glitch_done has priority over timeout in the same cycle.
REQ-023 arm deasserting during FIRE shall not drop trigger; the handshake always completes or times out.
REQ-024 HOLDOFF: trigger=0; wait until glitch_done=0 AND HOLDOFF_CYCLES cycles have elapsed since entry, then go to IDLE (edge_count cleared); with HOLDOFF_CYCLES=0, exit as soon as glitch_done=0.
REQ-025 edge_count shall saturate at 16'hFFFF and never wrap.
REQ-026 fault_indicator shall clear only on reset or on the IDLE->ARMED transition.
REQ-027 Edges occurring outside ARMED shall be ignored and shall not be counted retroactively.

Reset
REQ-028 While rst_n=0, asynchronously: state=IDLE, trigger=0, armed_indicator=0, fault_indicator=0, edge_count=0, synchronizer flops=0, filtered level=0, all counters=0.
REQ-029 Reset asserted mid-FIRE shall drop trigger immediately, without waiting for clk.
REQ-030 Reset deassertion shall be synchronized internally; the first state change occurs no earlier than the second clk edge after rst_n rises.

Verification
REQ-031 Single fire: DEBOUNCE_CYCLES=4, EDGE_COUNT=1, arm=1, trig_in 0->1 held -> trigger=1 exactly 2+4+1 cycles after the input edge; glitch_done=1 -> trigger=0 the next cycle.
REQ-032 Bounce rejection: trig_in pulses of 3 cycles (DEBOUNCE_CYCLES=4) x10 -> edge_count=0, trigger never asserts.
REQ-033 Edge counting: EDGE_COUNT=3, edge_sel=1, five clean falling edges -> fire on the 3rd; edges 4-5 ignored; edge_count=3.
REQ-034 Timeout: TIMEOUT_CYCLES=100, glitch_done held 0 -> trigger falls after 100 cycles in FIRE; fault_indicator=1 until the next arming.
REQ-035 Holdoff: HOLDOFF_CYCLES=50, glitch_done stays high for 80 cycles -> IDLE is reached only after glitch_done falls; with glitch_done low after 10 cycles -> IDLE at cycle 50.
REQ-036 Async reset mid-FIRE: rst_n=0 between clk edges -> trigger=0 within that time; after release, a new arm plus edge fires normally.
